// File: rtl/gsim_param_if.sv
// Bundles the b-sample load port and the x result stream of the Gauss-Seidel solver.
interface gsim_param_if #(
    parameter int unsigned B_W  = 16,
    parameter int unsigned IT_W = 8
);
    logic                   in_en;
    logic signed [B_W-1:0]  b_in;
    logic [IT_W-1:0]        iter_max;
    logic [31:0]            tol;
    logic                   out_ready;
    logic                   out_valid;
    logic signed [31:0]     x_out;
    logic                   busy;
    logic [IT_W-1:0]        iter_cnt;
    logic                   converged;

    // Producer of b samples and consumer of results.
    modport master (
        output in_en, b_in, iter_max, tol, out_ready,
        input  out_valid, x_out, busy, iter_cnt, converged
    );

    // The solver itself.
    modport slave (
        input  in_en, b_in, iter_max, tol, out_ready,
        output out_valid, x_out, busy, iter_cnt, converged
    );
endinterface

// File: rtl/gsim_param.sv
// Gauss-Seidel solver for the banded system 20x[k] - 13(x[k-1]+x[k+1]) + 6(x[k-2]+x[k+2])
// - (x[k-3]+x[k+3]) = b[k] in Q16.16. Loads N b samples, sweeps one unknown per cycle,
// checks convergence after each sweep and streams x[0..N-1] out with ready/valid.
module gsim_param #(
    parameter int unsigned N    = 16,
    parameter int unsigned B_W  = 16,
    parameter int unsigned IT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    gsim_param_if.slave bus_io
);
    localparam int unsigned KW = $clog2(N);
    // floor(2^33 / 20): multiply-and-shift replaces the divide by 20.
    localparam logic signed [72:0] Recip20 = 73'sd429496729;

    typedef enum logic [2:0] {StIdle, StLoad, StSweep, StCheck, StOutput} state_e;

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q;
    logic [KW-1:0]           ptr_q;
    logic [IT_W-1:0]         iter_max_q;
    logic [IT_W-1:0]         iter_cnt_q;
    logic [31:0]             tol_q;
    logic [31:0]             maxd_q;
    logic                    converged_q;
    logic signed [31:0]      b_q [N];
    logic signed [31:0]      x_q [N];

    logic signed [31:0]      b_fix;
    logic                    last_k;
    logic                    last_ptr;
    logic                    tol_met;
    logic                    iter_done;
    logic signed [39:0]      pair_sum [1:3];
    logic signed [39:0]      num;
    logic signed [72:0]      prod;
    logic signed [31:0]      x_new;
    logic signed [32:0]      diff;
    logic [32:0]             absd;
    logic [31:0]             maxd_next;

    assign b_fix     = 32'(bus_io.b_in) << 16;
    assign last_k    = (k_q == KW'(N - 1));
    assign last_ptr  = (ptr_q == KW'(N - 1));
    assign tol_met   = (maxd_q <= tol_q);
    assign iter_done = ((iter_cnt_q + IT_W'(1)) == iter_max_q);

    // Neighbour pair sums at distance 1..3; indices outside 0..N-1 contribute 0.
    // x_q below k already holds this sweep's values, which gives the Gauss-Seidel ordering.
    always_comb begin
        for (int d = 1; d <= 3; d++) begin
            pair_sum[d] = '0;
            if (int'(k_q) >= d) begin
                pair_sum[d] = pair_sum[d] + 40'(x_q[k_q - KW'(d)]);
            end
            if (int'(k_q) + d < int'(N)) begin
                pair_sum[d] = pair_sum[d] + 40'(x_q[k_q + KW'(d)]);
            end
        end
    end

    // Update of x[k_q] and the running max |x_new - x_old|.
    always_comb begin
        num       = 40'(b_q[k_q]) + 40'sd13 * pair_sum[1] - 40'sd6 * pair_sum[2] + pair_sum[3];
        prod      = 73'(num) * Recip20;
        x_new     = 32'(prod >>> 33);
        diff      = 33'(x_new) - 33'(x_q[k_q]);
        absd      = diff[32] ? 33'(-diff) : 33'(diff);
        maxd_next = (absd > {1'b0, maxd_q}) ? absd[31:0] : maxd_q;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus_io.in_en) state_d = StLoad;
            end
            StLoad: begin
                if (!bus_io.in_en) begin
                    state_d = StIdle;
                end else if (last_k) begin
                    state_d = (iter_max_q == '0) ? StOutput : StSweep;
                end
            end
            StSweep: begin
                if (last_k) state_d = StCheck;
            end
            StCheck: begin
                state_d = (tol_met || iter_done) ? StOutput : StSweep;
            end
            StOutput: begin
                if (bus_io.out_ready && last_ptr) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Datapath: sample storage, sweep index, iteration bookkeeping and output pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_q         <= '0;
            ptr_q       <= '0;
            iter_max_q  <= '0;
            iter_cnt_q  <= '0;
            tol_q       <= '0;
            maxd_q      <= '0;
            converged_q <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                b_q[i] <= '0;
                x_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus_io.in_en) begin
                        b_q[0]      <= b_fix;
                        x_q[0]      <= b_fix;
                        k_q         <= KW'(1);
                        iter_max_q  <= bus_io.iter_max;
                        tol_q       <= bus_io.tol;
                        iter_cnt_q  <= '0;
                        maxd_q      <= '0;
                        converged_q <= 1'b0;
                        ptr_q       <= '0;
                    end
                end
                StLoad: begin
                    if (bus_io.in_en) begin
                        b_q[k_q] <= b_fix;
                        x_q[k_q] <= b_fix;
                        k_q      <= last_k ? '0 : k_q + KW'(1);
                    end else begin
                        k_q <= '0;
                    end
                end
                StSweep: begin
                    x_q[k_q] <= x_new;
                    maxd_q   <= maxd_next;
                    k_q      <= last_k ? '0 : k_q + KW'(1);
                end
                StCheck: begin
                    iter_cnt_q <= iter_cnt_q + IT_W'(1);
                    if (tol_met) begin
                        converged_q <= 1'b1;
                    end else if (!iter_done) begin
                        maxd_q <= '0;
                    end
                end
                StOutput: begin
                    if (bus_io.out_ready) ptr_q <= last_ptr ? '0 : ptr_q + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus_io.out_valid = (state_q == StOutput);
    assign bus_io.busy      = (state_q != StIdle);
    assign bus_io.x_out     = (state_q == StOutput) ? x_q[ptr_q] : '0;
    assign bus_io.iter_cnt  = iter_cnt_q;
    assign bus_io.converged = converged_q;
endmodule

// File: tb/tb_gsim_param.sv
// Directed bench for gsim_param: three instances (N=16, 8, 32) share the stimulus and one is
// selected at a time; a bit-exact reference model supplies expected x vectors.
module tb_gsim_param;
    localparam int unsigned B_W  = 16;
    localparam int unsigned IT_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int                 sel;
    logic               in_en;
    logic               out_ready;
    logic signed [15:0] b_in;
    logic [7:0]         iter_max;
    logic [31:0]        tol;

    gsim_param_if #(.B_W(B_W), .IT_W(IT_W)) if16 ();
    gsim_param_if #(.B_W(B_W), .IT_W(IT_W)) if8 ();
    gsim_param_if #(.B_W(B_W), .IT_W(IT_W)) if32 ();

    assign if16.in_en     = in_en && (sel == 0);
    assign if8.in_en      = in_en && (sel == 1);
    assign if32.in_en     = in_en && (sel == 2);
    assign if16.b_in      = b_in;
    assign if8.b_in       = b_in;
    assign if32.b_in      = b_in;
    assign if16.iter_max  = iter_max;
    assign if8.iter_max   = iter_max;
    assign if32.iter_max  = iter_max;
    assign if16.tol       = tol;
    assign if8.tol        = tol;
    assign if32.tol       = tol;
    assign if16.out_ready = out_ready;
    assign if8.out_ready  = out_ready;
    assign if32.out_ready = out_ready;

    gsim_param #(.N(16), .B_W(B_W), .IT_W(IT_W)) u_dut16 (.clk(clk), .reset(reset), .bus_io(if16));
    gsim_param #(.N(8),  .B_W(B_W), .IT_W(IT_W)) u_dut8  (.clk(clk), .reset(reset), .bus_io(if8));
    gsim_param #(.N(32), .B_W(B_W), .IT_W(IT_W)) u_dut32 (.clk(clk), .reset(reset), .bus_io(if32));

    logic               o_valid, o_busy, o_conv;
    logic signed [31:0] o_x;
    logic [7:0]         o_cnt;

    always_comb begin
        o_valid = if16.out_valid;
        o_busy  = if16.busy;
        o_conv  = if16.converged;
        o_x     = if16.x_out;
        o_cnt   = if16.iter_cnt;
        if (sel == 1) begin
            o_valid = if8.out_valid;
            o_busy  = if8.busy;
            o_conv  = if8.converged;
            o_x     = if8.x_out;
            o_cnt   = if8.iter_cnt;
        end else if (sel == 2) begin
            o_valid = if32.out_valid;
            o_busy  = if32.busy;
            o_conv  = if32.converged;
            o_x     = if32.x_out;
            o_cnt   = if32.iter_cnt;
        end
    end

    int                 errors = 0;
    int                 checks = 0;
    int                 gm_b [64];
    logic signed [31:0] gm_x [64];
    int                 gm_iters;
    logic               gm_conv;
    logic signed [31:0] got [64];

    // Reference model: Gauss-Seidel with 40-bit numerator and floor(num*0x19999999 / 2^33).
    task automatic run_model(input int n, input int itmax, input logic [31:0] tolv);
        longint             num, d, maxd;
        logic signed [127:0] p;
        logic signed [31:0] nx;
        int                 c;
        for (int i = 0; i < n; i++) gm_x[i] = 32'(longint'(gm_b[i]) * 65536);
        gm_iters = 0;
        gm_conv  = 1'b0;
        while (itmax != 0) begin
            maxd = 0;
            for (int k = 0; k < n; k++) begin
                num = longint'(gm_b[k]) * 65536;
                for (int j = 1; j <= 3; j++) begin
                    c = (j == 1) ? 13 : ((j == 2) ? -6 : 1);
                    if (k - j >= 0) num += longint'(c) * longint'(gm_x[k - j]);
                    if (k + j < n)  num += longint'(c) * longint'(gm_x[k + j]);
                end
                p  = 128'(num) * 128'sd429496729;
                p  = p >>> 33;
                nx = p[31:0];
                d  = longint'(nx) - longint'(gm_x[k]);
                if (d < 0) d = -d;
                if (d > maxd) maxd = d;
                gm_x[k] = nx;
            end
            gm_iters++;
            if (maxd <= longint'(tolv)) begin
                gm_conv = 1'b1;
                break;
            end
            if (gm_iters == itmax) break;
        end
    endtask

    // Drives n samples from gm_b, one per cycle; returns in the cycle after the last sample.
    task automatic load(input int n, input int itmax, input logic [31:0] tolv);
        for (int i = 0; i < n; i++) begin
            in_en    = 1'b1;
            b_in     = 16'(gm_b[i]);
            iter_max = 8'(itmax);
            tol      = tolv;
            @(negedge clk);
        end
        in_en = 1'b0;
    endtask

    // Cycles from the last accepted sample to first out_valid; -1 if it never comes.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 20000) begin
            @(negedge clk);
            lat++;
        end
        if (!o_valid) lat = -1;
    endtask

    // Drains n words into got[]; pat 1 drives out_ready as 1,0,0,1,0,0,...
    task automatic collect(input int n, input int pat, output int got_n, output int stab_err);
        int                 cyc = 0;
        logic               held = 1'b0;
        logic signed [31:0] prev = '0;
        got_n    = 0;
        stab_err = 0;
        while (got_n < n && cyc < 400) begin
            out_ready = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
            if (held && (o_x !== prev || o_valid !== 1'b1)) stab_err++;
            if (o_valid && out_ready) begin
                got[got_n] = o_x;
                got_n++;
                held = 1'b0;
            end else begin
                held = o_valid;
                prev = o_x;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_en     = 1'b0;
        out_ready = 1'b0;
        b_in      = '0;
        iter_max  = '0;
        tol       = '0;
        sel       = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks += 5;
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        if (o_x !== 32'h0)    begin errors++; $display("FAIL reset_xout: got %h want 0", o_x); end
        if (o_cnt !== 8'h0)   begin errors++; $display("FAIL reset_cnt: got %0d want 0", o_cnt); end
        if (o_conv !== 1'b0)  begin errors++; $display("FAIL reset_conv: got %b want 0", o_conv); end
    endtask

    task automatic test_zeros();
        int lat, n_got, stab;
        sel = 0;
        for (int i = 0; i < 16; i++) gm_b[i] = 0;
        load(16, 120, 32'h0);
        wait_valid(lat);
        checks += 3;
        if (lat !== 18)      begin errors++; $display("FAIL zeros_latency: got %0d want 18", lat); end
        if (o_cnt !== 8'd1)  begin errors++; $display("FAIL zeros_cnt: got %0d want 1", o_cnt); end
        if (o_conv !== 1'b1) begin errors++; $display("FAIL zeros_conv: got %b want 1", o_conv); end
        collect(16, 0, n_got, stab);
        checks++;
        if (n_got !== 16) begin errors++; $display("FAIL zeros_count: got %0d want 16", n_got); end
        for (int i = 0; i < n_got; i++) begin
            checks++;
            if (got[i] !== 32'h0) begin
                errors++;
                $display("FAIL zeros_word%0d: got %h want 00000000", i, got[i]);
            end
        end
        checks += 2;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL zeros_idle_valid: got %b want 0", o_valid); end
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL zeros_idle_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_single_iter(input int pat);
        int lat, n_got, stab, extra;
        sel = 0;
        for (int i = 0; i < 16; i++) gm_b[i] = 0;
        gm_b[0] = 20;
        run_model(16, 1, 32'h0);
        load(16, 1, 32'h0);
        wait_valid(lat);
        checks += 3;
        if (lat !== 18)      begin errors++; $display("FAIL single_latency: got %0d want 18", lat); end
        if (o_cnt !== 8'd1)  begin errors++; $display("FAIL single_cnt: got %0d want 1", o_cnt); end
        if (o_conv !== 1'b0) begin errors++; $display("FAIL single_conv: got %b want 0", o_conv); end
        collect(16, pat, n_got, stab);
        checks += 3;
        if (n_got !== 16) begin errors++; $display("FAIL single_count: got %0d want 16", n_got); end
        if (stab !== 0)   begin errors++; $display("FAIL single_hold: got %0d unstable want 0", stab); end
        if (got[0] !== 32'h0000FFFF) begin
            errors++;
            $display("FAIL single_x0: got %h want 0000ffff", got[0]);
        end
        for (int i = 1; i < n_got; i++) begin
            checks++;
            if (got[i] !== gm_x[i]) begin
                errors++;
                $display("FAIL single_word%0d: got %h want %h", i, got[i], gm_x[i]);
            end
        end
        extra = 0;
        out_ready = 1'b1;
        repeat (8) begin
            if (o_valid) extra++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks += 2;
        if (extra !== 0)     begin errors++; $display("FAIL single_extra: got %0d want 0", extra); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_abort();
        int lat, n_got, stab, seen;
        sel = 0;
        for (int i = 0; i < 16; i++) gm_b[i] = 100 - 9 * i;
        load(5, 3, 32'h0);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", o_busy); end
        seen = 0;
        repeat (40) begin
            if (o_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_valid: got %0d want 0", seen); end
        for (int i = 0; i < 16; i++) gm_b[i] = i * 37 - 200;
        run_model(16, 3, 32'h0);
        load(16, 3, 32'h0);
        wait_valid(lat);
        checks += 3;
        if (lat !== gm_iters * 17 + 1) begin
            errors++;
            $display("FAIL abort_reload_latency: got %0d want %0d", lat, gm_iters * 17 + 1);
        end
        if (o_cnt !== 8'(gm_iters)) begin
            errors++;
            $display("FAIL abort_reload_cnt: got %0d want %0d", o_cnt, gm_iters);
        end
        if (o_conv !== gm_conv) begin
            errors++;
            $display("FAIL abort_reload_conv: got %b want %b", o_conv, gm_conv);
        end
        collect(16, 0, n_got, stab);
        checks++;
        if (n_got !== 16) begin errors++; $display("FAIL abort_reload_count: got %0d want 16", n_got); end
        for (int i = 0; i < n_got; i++) begin
            checks++;
            if (got[i] !== gm_x[i]) begin
                errors++;
                $display("FAIL abort_reload_word%0d: got %h want %h", i, got[i], gm_x[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, n_got, stab;
        logic signed [31:0] want;
        sel = 0;
        for (int i = 0; i < 16; i++) gm_b[i] = (i * 113) % 200 - 100;
        load(16, 10, 32'h0);
        // Now in cycle 1 after the last sample; sweep 3 cycle 7 is cycle 2*17+1+7 = 42.
        repeat (41) @(negedge clk);
        checks += 2;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b want 1", o_busy); end
        if (o_cnt !== 8'd2)  begin errors++; $display("FAIL midreset_pre_cnt: got %0d want 2", o_cnt); end
        reset = 1'b1;
        @(negedge clk);
        checks += 4;
        if (o_busy !== 1'b0)  begin errors++; $display("FAIL midreset_busy: got %b want 0", o_busy); end
        if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", o_valid); end
        if (o_cnt !== 8'd0)   begin errors++; $display("FAIL midreset_cnt: got %0d want 0", o_cnt); end
        if (o_x !== 32'h0)    begin errors++; $display("FAIL midreset_xout: got %h want 0", o_x); end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) gm_b[i] = 5 - 3 * i;
        load(16, 0, 32'h0);
        wait_valid(lat);
        checks += 3;
        if (lat !== 1)       begin errors++; $display("FAIL zeroiter_latency: got %0d want 1", lat); end
        if (o_cnt !== 8'd0)  begin errors++; $display("FAIL zeroiter_cnt: got %0d want 0", o_cnt); end
        if (o_conv !== 1'b0) begin errors++; $display("FAIL zeroiter_conv: got %b want 0", o_conv); end
        collect(16, 0, n_got, stab);
        checks++;
        if (n_got !== 16) begin errors++; $display("FAIL zeroiter_count: got %0d want 16", n_got); end
        for (int i = 0; i < n_got; i++) begin
            want = 32'(gm_b[i] * 65536);
            checks++;
            if (got[i] !== want) begin
                errors++;
                $display("FAIL zeroiter_word%0d: got %h want %h", i, got[i], want);
            end
        end
    endtask

    task automatic test_random(input int s, input int n);
        int lat, n_got, stab;
        sel = s;
        for (int i = 0; i < n; i++) gm_b[i] = int'($urandom_range(65535)) - 32768;
        gm_b[0] = 32767;
        gm_b[n - 1] = -32768;
        run_model(n, 200, 32'h10);
        load(n, 200, 32'h10);
        wait_valid(lat);
        checks += 3;
        if (lat !== gm_iters * (n + 1) + 1) begin
            errors++;
            $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, gm_iters * (n + 1) + 1);
        end
        if (o_cnt !== 8'(gm_iters)) begin
            errors++;
            $display("FAIL rand%0d_cnt: got %0d want %0d", n, o_cnt, gm_iters);
        end
        if (o_conv !== gm_conv) begin
            errors++;
            $display("FAIL rand%0d_conv: got %b want %b", n, o_conv, gm_conv);
        end
        collect(n, 1, n_got, stab);
        checks += 2;
        if (n_got !== n) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", n, n_got, n); end
        if (stab !== 0)  begin errors++; $display("FAIL rand%0d_hold: got %0d want 0", n, stab); end
        for (int i = 0; i < n_got; i++) begin
            checks++;
            if (got[i] !== gm_x[i]) begin
                errors++;
                $display("FAIL rand%0d_word%0d: got %h want %h", n, i, got[i], gm_x[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_single_iter(0);
        test_single_iter(1);
        test_abort();
        test_reset_mid();
        test_random(1, 8);
        test_random(2, 32);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gsim_param.md
GSIM_PARAM -- requirements
Module: gsim_param

Interface
REQ-001 Parameter N, default 16, number of unknowns (legal 8..64).
REQ-002 Parameter B_W, default 16, width of signed b input samples.
REQ-003 Parameter IT_W, default 8, width of iteration-limit and iteration-count ports.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_en  input  1  b sample valid; one sample is accepted per cycle.
REQ-007 b_in  input  B_W  signed integer b value, ordered b[0] first.
REQ-008 iter_max  input  IT_W  iteration limit, sampled with the first accepted b sample.
REQ-009 tol  input  32  unsigned Q16.16 convergence tolerance, sampled with the first accepted b sample.
REQ-010 out_ready  input  1  downstream accepts x_out this cycle.
REQ-011 out_valid  output  1  x_out holds a valid result word.
REQ-012 x_out  output  32  signed Q16.16 result x[k], ordered k=0..N-1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 iter_cnt  output  IT_W  number of completed sweeps; held through OUTPUT.
REQ-015 converged  output  1  high in OUTPUT if the exit was caused by the tolerance test.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SWEEP, CHECK and OUTPUT.
REQ-017 IDLE: in_en=1 SHALL store b[0] and sample iter_max and tol, then move to LOAD; otherwise stay in IDLE.
REQ-018 LOAD: each in_en=1 cycle SHALL store the next b[k]; storing b[N-1] SHALL move to SWEEP, or to OUTPUT if iter_max==0.
REQ-019 LOAD: in_en=0 before N samples SHALL abort the load to IDLE, discard the partial data, and drive no output.
REQ-020 Each stored b[k] SHALL be held as {b_in,16'b0} (Q16.16), and x[k] SHALL be initialised to the same value.
REQ-021 in_en SHALL be ignored in SWEEP, CHECK and OUTPUT.
REQ-022 SWEEP SHALL update exactly one unknown per cycle, k=0..N-1, so one sweep takes N cycles.
REQ-023 Each update SHALL compute x[k] = (b[k] + 13(x[k-1]+x[k+1]) - 6(x[k-2]+x[k+2]) + (x[k-3]+x[k+3])) / 20.
REQ-024 Any neighbour index outside 0..N-1 SHALL contribute 0.
REQ-025 The update SHALL be Gauss-Seidel: indices below k use values already updated in the current sweep.
REQ-026 The numerator SHALL be formed in 40-bit signed arithmetic with no overflow.
REQ-027 Division by 20 SHALL multiply the numerator by the 33-bit constant 0x019999999 and take product bits [64:33] (arithmetic shift, floor).
REQ-028 During a sweep the block SHALL track maxd = max |x_new - x_old| over all k (unsigned, 32-bit).
REQ-029 CHECK SHALL last 1 cycle and increment iter_cnt.
REQ-030 CHECK SHALL go to OUTPUT with converged=1 if maxd <= tol.
REQ-031 Otherwise, CHECK SHALL go to OUTPUT with converged=0 if iter_cnt+1 == iter_max.
REQ-032 Otherwise, CHECK SHALL clear maxd and return to SWEEP.
REQ-033 If both exit conditions hold in the same CHECK cycle, converged SHALL be 1.
REQ-034 OUTPUT: out_valid SHALL be 1 and x_out SHALL equal x[ptr], with ptr starting at 0.
REQ-035 OUTPUT: ptr SHALL advance only on out_valid & out_ready.
REQ-036 OUTPUT: while out_ready=0, x_out SHALL hold stable.
REQ-037 Acceptance of x[N-1] SHALL return the FSM to IDLE, deassert out_valid the next cycle, and clear ptr.
REQ-038 Latency from the cycle b[N-1] is accepted to the first out_valid SHALL be s*(N+1)+1 cycles for s sweeps, and 1 cycle when iter_max==0.
REQ-039 iter_max==0 SHALL output x=b·2^16 with iter_cnt=0 and converged=0.

Reset
REQ-040 reset=1 SHALL, at the next edge and in any state (mid-load, mid-sweep, mid-output), force IDLE.
REQ-041 reset SHALL clear out_valid, busy, converged, iter_cnt, ptr, maxd and all x/b storage.
REQ-042 x_out SHALL read 0 while out_valid=0 after reset.
REQ-043 The cycle after reset deasserts, the block SHALL accept in_en.

Verification
REQ-044 N=16, all b=0, iter_max=120, tol=0 -> 16 words of 0x00000000, iter_cnt=1, converged=1.
REQ-045 N=16, b[0]=20, others 0, iter_max=1, tol=0 -> x_out[0]=0x0000FFFF (truncating divide), iter_cnt=1, converged=0.
REQ-046 Run REQ-045 with out_ready toggled 1,0,0,1,... -> each word held stable while out_ready=0; exactly 16 acceptances, then IDLE.
REQ-047 in_en drops after 5 samples -> FSM returns to IDLE, out_valid never asserts; a following full 16-sample load behaves normally.
REQ-048 reset asserted at SWEEP cycle 7 of iteration 3 -> next cycle busy=0, out_valid=0, iter_cnt=0.
REQ-049 Random b over the full B_W range, N=8 and N=32, iter_max=200, tol=0x00000010 -> x_out matches the bit-exact golden model, iter_cnt matches, converged=1.
